// File: rtl/accum_table_wr_seq.sv
// accum_table_wr_seq
//   Write-side sequencer feeding the accumulator-table write-address control
//   stage. A start in IDLE captures the sub-matrix position, waits out the
//   systolic-array fill latency, issues one write enable per sub-row and then
//   waits for the column skew to drain before pulsing done.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         request one pass; sampled only in IDLE
//   abort         synchronous cancel of the current pass
//   submat_m_in   sub-matrix row position, captured with start
//   submat_n_in   sub-matrix column position, captured with start
//   wr_en_out     write enable to the write-address control stage
//   sub_row_out   row index within the sub-matrix
//   submat_m_out  captured sub-matrix row position
//   submat_n_out  captured sub-matrix column position
//   busy          high while a pass is in progress
//   done          one-cycle pulse in the final drain cycle
module accum_table_wr_seq #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_ROWS = 16,
    parameter int unsigned SYS_ARR_COLS = 16,
    parameter int unsigned FILL_CYCLES  = 16,
    localparam int unsigned MCount = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int unsigned NCount = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int unsigned MW     = (MCount > 1) ? $clog2(MCount) : 1,
    localparam int unsigned NW     = (NCount > 1) ? $clog2(NCount) : 1,
    localparam int unsigned RW     = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1,
    localparam int unsigned CntMax = (FILL_CYCLES > SYS_ARR_COLS) ? FILL_CYCLES : SYS_ARR_COLS,
    localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [MW-1:0] submat_m_in,
    input  logic [NW-1:0] submat_n_in,
    output logic          wr_en_out,
    output logic [RW-1:0] sub_row_out,
    output logic [MW-1:0] submat_m_out,
    output logic [NW-1:0] submat_n_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDrain} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;     // shared by FILL and DRAIN; counts down to 0
    logic [RW-1:0] row_q;
    logic          wr_en_q;
    logic [MW-1:0] m_q;
    logic [NW-1:0] n_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
            wr_en_q <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            // Highest priority; in IDLE this leaves everything unchanged and
            // also swallows a simultaneous start.
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_q     <= submat_m_in;
                        n_q     <= submat_n_in;
                        cnt_q   <= CW'(FILL_CYCLES - 1);
                        state_q <= StFill;
                        busy_q  <= 1'b1;
                    end
                end
                StFill: begin
                    if (cnt_q == '0) begin
                        state_q <= StWrite;
                        wr_en_q <= 1'b1;
                        row_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StWrite: begin
                    if (row_q == RW'(SYS_ARR_ROWS - 1)) begin
                        state_q <= StDrain;
                        wr_en_q <= 1'b0;
                        row_q   <= '0;
                        cnt_q   <= CW'(SYS_ARR_COLS - 1);
                        // A one-cycle drain makes its first cycle the last one.
                        done_q  <= (SYS_ARR_COLS == 1);
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                StDrain: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CW'(1);
                        done_q <= (cnt_q == CW'(1));
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en_out    = wr_en_q;
    assign sub_row_out  = row_q;
    assign submat_m_out = m_q;
    assign submat_n_out = n_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_accum_table_wr_seq.sv
module tb_accum_table_wr_seq;

    localparam int DF = 16, DR = 16, DC = 16;  // default DUT
    localparam int SF = 1, SR = 4, SC = 2;     // small DUT

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic       start = 1'b0, abort = 1'b0;
    logic [2:0] m_in = '0, n_in = '0;
    logic       wr_en, busy, done;
    logic [3:0] row;
    logic [2:0] m_out, n_out;

    // Small-parameter DUT
    logic       start_s = 1'b0, abort_s = 1'b0;
    logic [4:0] m_in_s = '0;
    logic [5:0] n_in_s = '0;
    logic       wr_en_s, busy_s, done_s;
    logic [1:0] row_s;
    logic [4:0] m_out_s;
    logic [5:0] n_out_s;

    accum_table_wr_seq u_dut (
        .clk(clk), .reset(rst), .start(start), .abort(abort),
        .submat_m_in(m_in), .submat_n_in(n_in),
        .wr_en_out(wr_en), .sub_row_out(row),
        .submat_m_out(m_out), .submat_n_out(n_out),
        .busy(busy), .done(done)
    );

    accum_table_wr_seq #(
        .FILL_CYCLES(SF), .SYS_ARR_ROWS(SR), .SYS_ARR_COLS(SC)
    ) u_small (
        .clk(clk), .reset(rst), .start(start_s), .abort(abort_s),
        .submat_m_in(m_in_s), .submat_n_in(n_in_s),
        .wr_en_out(wr_en_s), .sub_row_out(row_s),
        .submat_m_out(m_out_s), .submat_n_out(n_out_s),
        .busy(busy_s), .done(done_s)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: a pass is just "cycles elapsed since the accepting edge".
    bit mb, sb;
    int mt, st, mm, mn, sm, sn;

    task automatic model_step(inout bit b, inout int t, inout int m, inout int n,
                              input bit s, input bit a, input int mi, input int ni,
                              input int f, input int r, input int c);
        if (a) begin
            b = 1'b0;
            t = 0;
        end else if (b) begin
            t++;
            if (t == f + r + c) begin
                b = 1'b0;
                t = 0;
            end
        end else if (s) begin
            b = 1'b1;
            t = 0;
            m = mi;
            n = ni;
        end
    endtask

    function automatic logic [26:0] exp_vec(bit b, int t, int m, int n, int f, int r, int c);
        bit we, dn;
        int rw;
        we = b && (t >= f) && (t < f + r);
        rw = we ? t - f : 0;
        dn = b && (t == f + r + c - 1);
        return {we, 8'(rw), 8'(m), 8'(n), b, dn};
    endfunction

    function automatic logic [26:0] obs_main();
        return {wr_en, 8'(row), 8'(m_out), 8'(n_out), busy, done};
    endfunction

    function automatic logic [26:0] obs_small();
        return {wr_en_s, 8'(row_s), 8'(m_out_s), 8'(n_out_s), busy_s, done_s};
    endfunction

    task automatic model_reset();
        mb = 0; mt = 0; mm = 0; mn = 0;
        sb = 0; st = 0; sm = 0; sn = 0;
    endtask

    // Advance one edge, update both models with the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_step(mb, mt, mm, mn, start, abort, int'(m_in), int'(n_in), DF, DR, DC);
            model_step(sb, st, sm, sn, start_s, abort_s, int'(m_in_s), int'(n_in_s), SF, SR, SC);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] e;
        model_reset();
        #2;
        e = '0;
        n_checks++;
        if (obs_main() !== e) begin
            n_fails++;
            $display("FAIL reset_main got=%h want=%h", obs_main(), e);
        end
        n_checks++;
        if (obs_small() !== e) begin
            n_fails++;
            $display("FAIL reset_small got=%h want=%h", obs_small(), e);
        end
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single_pass();
        int en_cnt = 0, first_en = -1, done_at = -1, done_cnt = 0, idle_at = -1;
        bit order_ok = 1'b1;
        logic [26:0] e;
        m_in = 3'd5; n_in = 3'd3; start = 1'b1;
        for (int k = 0; k < 52; k++) begin
            tick();
            if (k == 0) begin
                start = 1'b0;
                m_in = 3'd7; n_in = 3'd7;  // must not disturb the captured position
            end
            e = exp_vec(mb, mt, mm, mn, DF, DR, DC);
            n_checks++;
            if (obs_main() !== e) begin
                n_fails++;
                $display("FAIL single_pass edge=%0d got=%h want=%h", k, obs_main(), e);
            end
            if (wr_en === 1'b1) begin
                if (first_en < 0) first_en = k;
                if (int'(row) != k - 16) order_ok = 1'b0;
                en_cnt++;
            end
            if (done === 1'b1) begin
                done_at = k;
                done_cnt++;
            end
            if (busy === 1'b0 && idle_at < 0) idle_at = k;
        end
        n_checks++;
        if (first_en != 16 || en_cnt != 16 || !order_ok) begin
            n_fails++;
            $display("FAIL single_wr_window first=%0d count=%0d order=%0d want 16/16/1",
                     first_en, en_cnt, order_ok);
        end
        n_checks++;
        if (done_at != 47 || done_cnt != 1 || idle_at != 48) begin
            n_fails++;
            $display("FAIL single_done done_at=%0d n=%0d idle_at=%0d want 47/1/48",
                     done_at, done_cnt, idle_at);
        end
    endtask

    task automatic test_back_to_back();
        int en_cnt = 0, dn_idx = 0;
        int dn_at[3] = '{-1, -1, -1};
        logic [26:0] e;
        start = 1'b1;
        for (int k = 0; k < 147; k++) begin
            m_in = 3'($urandom);
            n_in = 3'($urandom);
            tick();
            e = exp_vec(mb, mt, mm, mn, DF, DR, DC);
            n_checks++;
            if (obs_main() !== e) begin
                n_fails++;
                $display("FAIL back_to_back edge=%0d got=%h want=%h", k, obs_main(), e);
            end
            if (wr_en === 1'b1) en_cnt++;
            if (done === 1'b1) begin
                if (dn_idx < 3) dn_at[dn_idx] = k;
                dn_idx++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (en_cnt != 48 || dn_idx != 3 || dn_at[0] != 47 || dn_at[1] != 96 || dn_at[2] != 145)
        begin
            n_fails++;
            $display("FAIL back_to_back_sched en=%0d dones=%0d at %0d,%0d,%0d want 48/3 at 47,96,145",
                     en_cnt, dn_idx, dn_at[0], dn_at[1], dn_at[2]);
        end
    endtask

    task automatic test_abort();
        int dn_cnt = 0, en_cnt = 0;
        logic [26:0] e;
        tick();  // idle gap
        m_in = 3'd2; n_in = 3'd6; start = 1'b1;
        for (int k = 0; k < 72; k++) begin
            tick();
            start = (k == 21);  // restart sampled at edge 22
            abort = (k == 20);  // abort sampled at edge 21
            e = exp_vec(mb, mt, mm, mn, DF, DR, DC);
            n_checks++;
            if (obs_main() !== e) begin
                n_fails++;
                $display("FAIL abort edge=%0d got=%h want=%h", k, obs_main(), e);
            end
            if (k <= 22 && done === 1'b1) dn_cnt++;
            if (k == 21 && (wr_en !== 1'b0 || busy !== 1'b0)) dn_cnt += 100;
            if (k > 22 && wr_en === 1'b1) en_cnt++;
        end
        start = 1'b0;
        n_checks++;
        if (dn_cnt != 0 || en_cnt != 16) begin
            n_fails++;
            $display("FAIL abort_effect flags=%0d restart_en=%0d want 0/16", dn_cnt, en_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] e;
        tick();
        m_in = 3'($urandom); n_in = 3'($urandom); start = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            tick();
            start = 1'b0;
        end
        #4;
        rst = 1'b0;
        model_reset();
        #1;
        e = '0;
        n_checks++;
        if (obs_main() !== e) begin
            n_fails++;
            $display("FAIL reset_mid got=%h want=%h", obs_main(), e);
        end
        #2;
        rst = 1'b1;
        m_in = 3'd4; n_in = 3'd1; start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            start = 1'b0;
            e = exp_vec(mb, mt, mm, mn, DF, DR, DC);
            n_checks++;
            if (obs_main() !== e) begin
                n_fails++;
                $display("FAIL after_reset edge=%0d got=%h want=%h", k, obs_main(), e);
            end
        end
    endtask

    task automatic test_small();
        int first_en = -1, en_cnt = 0, done_at = -1, idle_at = -1;
        logic [26:0] e;
        m_in_s = 5'd19; n_in_s = 6'd42; start_s = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            start_s = 1'b0;
            e = exp_vec(sb, st, sm, sn, SF, SR, SC);
            n_checks++;
            if (obs_small() !== e) begin
                n_fails++;
                $display("FAIL small edge=%0d got=%h want=%h", k, obs_small(), e);
            end
            if (wr_en_s === 1'b1) begin
                if (first_en < 0) first_en = k;
                en_cnt++;
            end
            if (done_s === 1'b1) done_at = k;
            if (busy_s === 1'b0 && idle_at < 0) idle_at = k;
        end
        n_checks++;
        if (first_en != 1 || en_cnt != 4 || done_at != 6 || idle_at != 7) begin
            n_fails++;
            $display("FAIL small_sched first=%0d en=%0d done=%0d idle=%0d want 1/4/6/7",
                     first_en, en_cnt, done_at, idle_at);
        end
    endtask

    task automatic test_random();
        logic [26:0] e;
        for (int k = 0; k < 400; k++) begin
            start   = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 29) == 0);
            m_in    = 3'($urandom);
            n_in    = 3'($urandom);
            start_s = ($urandom_range(0, 2) == 0);
            abort_s = ($urandom_range(0, 11) == 0);
            m_in_s  = 5'($urandom);
            n_in_s  = 6'($urandom);
            tick();
            e = exp_vec(mb, mt, mm, mn, DF, DR, DC);
            n_checks++;
            if (obs_main() !== e) begin
                n_fails++;
                $display("FAIL random_main cyc=%0d got=%h want=%h", k, obs_main(), e);
            end
            e = exp_vec(sb, st, sm, sn, SF, SR, SC);
            n_checks++;
            if (obs_small() !== e) begin
                n_fails++;
                $display("FAIL random_small cyc=%0d got=%h want=%h", k, obs_small(), e);
            end
        end
        start = 1'b0; abort = 1'b0; start_s = 1'b0; abort_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_small();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/accum_table_wr_seq.md
Name: accum_table_wr_seq

Overview:
- Write-side sequencer that sits directly upstream of the accumulator-table write-address control stage.
- On a start command it waits for the systolic array fill latency.
- It then issues one write-enable per cycle with the sub-row index for all SYS_ARR_ROWS rows of one output sub-matrix, tagged with that sub-matrix's (m, n) position.
- It then waits for the column skew to drain and signals done.

Parameters:
- MAX_OUT_ROWS, 128, maximum output-matrix rows.
- MAX_OUT_COLS, 128, maximum output-matrix columns.
- SYS_ARR_ROWS, 16, systolic array rows; number of write-enable cycles per sub-matrix.
- SYS_ARR_COLS, 16, systolic array columns; drain length in cycles.
- FILL_CYCLES, 16, cycles from accepted start to the first write-enable. Must be >= 1.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one sub-matrix write pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current pass.
- submat_m_in  in  $clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)  sub-matrix row position; captured with start.
- submat_n_in  in  $clog2(MAX_OUT_COLS/SYS_ARR_COLS)  sub-matrix column position; captured with start.
- wr_en_out  out  1  write enable to the write-address control stage.
- sub_row_out  out  $clog2(SYS_ARR_ROWS)  row index within the sub-matrix.
- submat_m_out  out  same as submat_m_in  captured sub-matrix row position.
- submat_n_out  out  same as submat_n_in  captured sub-matrix column position.
- busy  out  1  high while a pass is in progress (state != IDLE).
- done  out  1  one-cycle pulse when the pass is complete.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE, counters=0.
  - wr_en_out=0, sub_row_out=0, submat_m_out=0, submat_n_out=0, busy=0, done=0.
  - Takes effect immediately, including mid-pass; no done is produced for an interrupted pass.
- States and transitions (edge 0 = the edge at which start is sampled high in IDLE):
  - IDLE:
    - start=1 -> capture submat_m_in/submat_n_in into submat_m_out/submat_n_out; load fill counter with FILL_CYCLES-1; go to FILL; busy=1 after edge 0.
    - start=0 -> stay in IDLE; wr_en_out=0, sub_row_out=0; submat_*_out hold their last value.
  - FILL:
    - Counter decrements each cycle; wr_en_out=0.
    - At count 0 -> WRITE with row counter=0.
    - wr_en_out is first high after edge FILL_CYCLES.
  - WRITE:
    - wr_en_out=1 and sub_row_out=row counter, which increments 0..SYS_ARR_ROWS-1, one per cycle.
    - With defaults, wr_en_out is high after edges 16..31.
    - After row SYS_ARR_ROWS-1 -> DRAIN; wr_en_out=0 and sub_row_out=0 from the next cycle.
    - No wrap: exactly SYS_ARR_ROWS enables per pass.
  - DRAIN:
    - Lasts SYS_ARR_COLS cycles; wr_en_out=0.
    - done=1 during the final DRAIN cycle only, i.e. after edge FILL_CYCLES+SYS_ARR_ROWS+SYS_ARR_COLS-1 (47 with defaults).
    - Then -> IDLE; busy=0 from the following cycle.
- start while busy=1 is ignored and not queued. This includes the done cycle.
- The earliest accepted restart is the first IDLE cycle after done.
- abort=1 in any non-IDLE state:
  - Next edge -> IDLE; wr_en_out=0, busy=0, done stays 0.
  - abort has priority over all other transitions.
  - abort in IDLE has no effect; a simultaneous start is ignored.
- submat_*_out are constant for the entire pass and unaffected by input changes after capture.
- Widths: counters are sized by $clog2 of their maximum count.
  - A minimum of 1 bit applies when the count is 1.
  - sub_row_out wraps arithmetic is never exercised (counter stops at SYS_ARR_ROWS-1).

Test Plan:
- Reset at time 0, then start=1 for one cycle with submat_m_in=5, submat_n_in=3 (defaults):
  - wr_en_out high after edges 16..31 with sub_row_out 0..15 in order.
  - submat_m_out=5 and submat_n_out=3 throughout the pass.
  - done high only after edge 47; busy low after edge 48.
- Change submat_m_in/submat_n_in to 7/7 after edge 0 -> outputs remain 5/3 for the pass.
- Hold start=1 continuously -> passes begin at edges 0, 49, 98; exactly 16 enables per pass; done pulses after edges 47, 96, 145.
- Assert abort after edge 20 (mid-WRITE) -> wr_en_out=0 and busy=0 after edge 21; no done pulse; a fresh start at edge 22 runs a full pass.
- Drop reset low asynchronously midway between edges 25 and 26 -> all outputs 0 immediately; release and start -> normal pass, submat outputs reflect the new capture.
- Run with parameter FILL_CYCLES=1, SYS_ARR_ROWS=4, SYS_ARR_COLS=2 -> wr_en_out high after edges 1..4, done after edge 6, busy low after edge 7.
